alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, clocked successor to the 8-bit combinational ALU: same 3-bit opcode set
//  (AND/OR/NOT/LSL/LSR/ADD/SUB/MUL), any WIDTH, registered results, valid/ready handshakes.
//  MUL is an iterative shift-add unit, so the block has real latency and backpressure.
//  Sits between the register-file read stage and write-back in the datapath.
// PARAMETERS
//  WIDTH   8   operand width in bits (>=4); results are WIDTH (lo) + WIDTH (hi)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operation request valid
//  in_ready   out  1      block can accept a request this cycle
//  op         in   3      000 AND,001 OR,010 NOT a,011 LSL a,100 LSR a,101 ADD,110 SUB,111 MUL
//  a, b       in   WIDTH  operands (unsigned)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer takes result this cycle
//  res_lo     out  WIDTH  result (MUL: low half)
//  res_hi     out  WIDTH  MUL high half; 0 for all other ops
//  flags      out  5      [0]Z [1]P(even parity of res_lo) [2]N(res_lo msb) [3]C [4]V
//  busy       out  1      multiply in progress
// BEHAVIOUR
//  - Reset: state IDLE, out_valid=0, res_lo=res_hi=0, flags=0, busy=0, cycle counter=0.
//  - Accept = in_valid & in_ready. in_ready = (state==IDLE) & (~out_valid | out_ready).
//  - Non-MUL: result/flags registered on the accept edge; out_valid=1 from next cycle.
//  - MUL: accept edge latches a,b, state->MUL, busy=1. Each following edge does one
//    shift-add step; on the WIDTH-th step the 2*WIDTH product is written, out_valid=1,
//    state->IDLE, busy=0. Latency = WIDTH cycles after accept. Inputs ignored while busy.
//  - Output register holds res_lo/res_hi/flags stable while out_valid & ~out_ready.
//    out_valid clears on out_ready unless a new accept loads it the same edge (1/cycle
//    throughput for non-MUL ops under continuous ready).
//  - LSL = {a[W-2:0],0}, C=a[W-1]. LSR = {0,a[W-1:1]}, C=a[0]. Logic ops: C=V=0.
//  - ADD: {C,res}=a+b; V = signed overflow. SUB: res=a+~b+1; C=1 means no borrow
//    (a>=b); V = signed overflow of a-b.
//  - MUL: C = (res_hi!=0); V=0. Z/P/N always computed from res_lo only.
//  - Reset mid-MUL aborts the operation; no result is produced; returns to IDLE.
//  - Edge cases: a=b=0 MUL -> 0, Z=1; all-ones ADD 1 wraps to 0, C=1, Z=1.
// CONFIGURATION
//  - ALU_FAST_MUL_EN defined: MUL is a single-cycle combinational multiply, treated like
//    any other op (latency 1, busy never asserted, MUL state unused).
//  - Undefined: iterative shift-add as above (WIDTH cycles), minimal area.
//  - Flags, handshake and results identical in both builds; only latency differs.
// STRUCTURE
//  - Package alu_pkg: opcode localparams (OP_AND..OP_MUL), flag bit indices
//    (FLG_Z,FLG_P,FLG_N,FLG_C,FLG_V), FSM state encoding (ST_IDLE, ST_MUL).
//  - Sub-module alu_mul_iter: start/done shift-add multiplier with its own counter
//    (clog2(WIDTH)+1 bits), partial-product and multiplier shift registers; omitted
//    from build when ALU_FAST_MUL_EN is defined.
//  - Top holds combinational logic-op/adder path, flag generation, output register, FSM.
// TESTING
//  1. ADD a=8'hFF b=8'h01, out_ready=1 -> next cycle res_lo=00, C=1, Z=1, V=0, P=1.
//  2. SUB a=8'h05 b=8'h07 -> res_lo=FE, C=0, N=1, V=0; SUB 8'h80-8'h01 -> 7F, V=1, C=1.
//  3. MUL a=8'hFF b=8'hFF -> out_valid exactly 8 cycles after accept, res_hi=FE,
//     res_lo=01, C=1; busy=1 and in_ready=0 throughout (1 cycle with ALU_FAST_MUL_EN).
//  4. LSL 8'h81 -> 02, C=1; LSR 8'h81 -> 40, C=1; NOT 8'h0F -> F0, N=1.
//  5. Backpressure: hold out_ready=0 3 cycles after AND result -> outputs stable,
//     in_ready=0; raise out_ready with new in_valid -> next result loads same edge.
//  6. Assert rst at step 4 of MUL -> next cycle out_valid=0, busy=0, in_ready=1; rerun
//     suite with WIDTH=16 (e.g. MUL 16'hFFFF*16'h0002 -> hi=0001, lo=FFFE).

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, flag bit indices and FSM states for alu_seq.
// Build option ALU_FAST_MUL_EN selects a single-cycle multiplier.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_LSL = 3'b011;
  localparam logic [2:0] OP_LSR = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam int FLG_Z = 0;
  localparam int FLG_P = 1;
  localparam int FLG_N = 2;
  localparam int FLG_C = 3;
  localparam int FLG_V = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: right-shifting shift-add multiplier, one step per cycle.
// Used by alu_seq unless ALU_FAST_MUL_EN is defined.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic             active;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH:0]   sum;

  assign sum  = {1'b0, acc}
              + (mplier[0] ? {1'b0, mcand} : '0);
  assign done = active & (cnt == CW'(WIDTH - 1));
  // Product as it will stand after this step's shift.
  assign prod = {sum, mplier[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      mcand  <= a;
      acc    <= '0;
      mplier <= b;
    end else if (active) begin
      acc    <= sum[WIDTH:1];
      mplier <= {sum[0], mplier[WIDTH-1:1]};
      cnt    <= cnt + CW'(1);
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes and iterative MUL.
// Build option ALU_FAST_MUL_EN selects a single-cycle multiplier.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [4:0]       flags,
  output logic             busy
);

  localparam int M = WIDTH - 1;

  state_t               state_q;
  state_t               state_d;
  logic                 accept;
  logic                 mul_go;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_prod;
  logic                 load;
  logic [WIDTH:0]       add_s;
  logic [WIDTH:0]       sub_s;
  logic [WIDTH-1:0]     r_lo;
  logic [WIDTH-1:0]     r_hi;
  logic                 r_c;
  logic                 r_v;
  logic [4:0]           r_fl;

  assign in_ready = (state_q == ST_IDLE)
                  & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign busy     = (state_q == ST_MUL);
  assign load     = mul_done | (accept & ~mul_go);

`ifdef ALU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fprod;

  assign mul_go   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
  assign fprod    = {{WIDTH{1'b0}}, a}
                  * {{WIDTH{1'b0}}, b};
`else
  assign mul_go = accept & (op == OP_MUL);

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_go),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .prod  (mul_prod)
  );
`endif

  assign add_s = {1'b0, a} + {1'b0, b};
  assign sub_s = {1'b0, a} + {1'b0, ~b}
               + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    r_lo = '0;
    r_hi = '0;
    r_c  = 1'b0;
    r_v  = 1'b0;
    if (mul_done) begin
      {r_hi, r_lo} = mul_prod;
      r_c = |mul_prod[2*WIDTH-1:WIDTH];
    end else begin
      unique case (op)
        OP_AND: r_lo = a & b;
        OP_OR:  r_lo = a | b;
        OP_NOT: r_lo = ~a;
        OP_LSL: begin
          r_lo = {a[M-1:0], 1'b0};
          r_c  = a[M];
        end
        OP_LSR: begin
          r_lo = {1'b0, a[M:1]};
          r_c  = a[0];
        end
        OP_ADD: begin
          r_lo = add_s[M:0];
          r_c  = add_s[WIDTH];
          r_v  = (a[M] == b[M]) & (add_s[M] != a[M]);
        end
        OP_SUB: begin
          r_lo = sub_s[M:0];
          r_c  = sub_s[WIDTH];
          r_v  = (a[M] != b[M]) & (sub_s[M] != a[M]);
        end
        OP_MUL: begin
`ifdef ALU_FAST_MUL_EN
          {r_hi, r_lo} = fprod;
          r_c = |fprod[2*WIDTH-1:WIDTH];
`endif
        end
      endcase
    end
  end

  always_comb begin
    r_fl        = '0;
    r_fl[FLG_Z] = ~|r_lo;
    r_fl[FLG_P] = ~^r_lo;
    r_fl[FLG_N] = r_lo[M];
    r_fl[FLG_C] = r_c;
    r_fl[FLG_V] = r_v;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (mul_go)   state_d = ST_MUL;
      ST_MUL:  if (mul_done) state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      out_valid <= 1'b0;
      res_lo    <= '0;
      res_hi    <= '0;
      flags     <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        out_valid <= 1'b1;
        res_lo    <= r_lo;
        res_hi    <= r_hi;
        flags     <= r_fl;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: checks alu_seq at WIDTH=8 and WIDTH=16 against an
// arithmetic reference model, plus handshake, backpressure and reset.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [2:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        sel16;

  logic        ir8, ov8, busy8;
  logic [7:0]  lo8, hi8;
  logic [4:0]  fl8;
  logic        ir16, ov16, busy16;
  logic [15:0] lo16, hi16;
  logic [4:0]  fl16;

  logic        o_ir, o_ov, o_busy;
  logic [15:0] o_lo, o_hi;
  logic [4:0]  o_fl;

  int checks   = 0;
  int failures = 0;
  int cw;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid & ~sel16),
    .in_ready  (ir8),
    .op        (op),
    .a         (a[7:0]),
    .b         (b[7:0]),
    .out_valid (ov8),
    .out_ready (out_ready),
    .res_lo    (lo8),
    .res_hi    (hi8),
    .flags     (fl8),
    .busy      (busy8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid & sel16),
    .in_ready  (ir16),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (ov16),
    .out_ready (out_ready),
    .res_lo    (lo16),
    .res_hi    (hi16),
    .flags     (fl16),
    .busy      (busy16)
  );

  assign o_ir   = sel16 ? ir16   : ir8;
  assign o_ov   = sel16 ? ov16   : ov8;
  assign o_busy = sel16 ? busy16 : busy8;
  assign o_lo   = sel16 ? lo16   : {8'h00, lo8};
  assign o_hi   = sel16 ? hi16   : {8'h00, hi8};
  assign o_fl   = sel16 ? fl16   : fl8;

  task automatic check(input string tag,
                       input longint obs,
                       input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int mul_lat(input int w);
`ifdef ALU_FAST_MUL_EN
    return 0;
`else
    return w;
`endif
  endfunction

  // Reference model from the arithmetic definition of each operation.
  task automatic model(input int w, input logic [2:0] o,
                       input longint ua, input longint ub,
                       output longint lo, output longint hi,
                       output logic [4:0] fl);
    longint m    = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint sa, sb, r, s;
    logic   c = 1'b0;
    logic   v = 1'b0;
    hi = 0;
    lo = 0;
    sa = (ua >= half) ? ua - (m + 1) : ua;
    sb = (ub >= half) ? ub - (m + 1) : ub;
    case (o)
      OP_AND: lo = ua & ub;
      OP_OR:  lo = ua | ub;
      OP_NOT: lo = ~ua & m;
      OP_LSL: begin
        lo = (ua * 2) & m;
        c  = ua >= half;
      end
      OP_LSR: begin
        lo = ua / 2;
        c  = (ua % 2) == 1;
      end
      OP_ADD: begin
        r  = ua + ub;
        lo = r & m;
        c  = r > m;
        s  = sa + sb;
        v  = (s > half - 1) || (s < -half);
      end
      OP_SUB: begin
        lo = (ua - ub) & m;
        c  = ua >= ub;
        s  = sa - sb;
        v  = (s > half - 1) || (s < -half);
      end
      default: begin
        r  = ua * ub;
        lo = r & m;
        hi = r >> w;
        c  = hi != 0;
      end
    endcase
    fl[0] = (lo == 0);
    fl[1] = ($countones(lo) % 2) == 0;
    fl[2] = lo >= half;
    fl[3] = c;
    fl[4] = v;
  endtask

  task automatic run_op(input logic [2:0] o,
                        input longint ua,
                        input longint ub,
                        input string tag);
    longint     elo, ehi;
    logic [4:0] efl;
    int         k, ek;
    model(cw, o, ua, ub, elo, ehi, efl);
    ek = (o == OP_MUL) ? mul_lat(cw) : 0;
    @(negedge clk);
    check({tag, ".in_ready"}, o_ir, 1);
    op        = o;
    a         = ua[15:0];
    b         = ub[15:0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a  = 16'($urandom);
    b  = 16'($urandom);
    op = 3'($urandom);
    k  = 0;
    while (!o_ov && k < 200) begin
      check({tag, ".busy"}, o_busy, 1);
      check({tag, ".blocked"}, o_ir, 0);
      @(negedge clk);
      k++;
    end
    check({tag, ".latency"}, k, ek);
    check({tag, ".lo"}, o_lo, elo);
    check({tag, ".hi"}, o_hi, ehi);
    check({tag, ".flags"}, o_fl, efl);
  endtask

  task automatic run_suite(input int w);
    longint     m    = (longint'(1) << w) - 1;
    longint     half = longint'(1) << (w - 1);
    longint     elo, ehi, slo;
    logic [4:0] efl, sfl;
    longint     ra, rb;
    cw    = w;
    sel16 = (w == 16);

    run_op(OP_ADD, m, 1, "add_wrap");
    check("add_wrap.const", o_fl, 5'b01011);
    run_op(OP_SUB, 5, 7, "sub_borrow");
    check("sub_borrow.const", o_lo, m - 1);
    run_op(OP_SUB, half, 1, "sub_ovf");
    check("sub_ovf.const", o_fl[4:3], 2'b11);
    run_op(OP_MUL, m, m, "mul_max");
    check("mul_max.hi_const", o_hi, m - 1);
    check("mul_max.lo_const", o_lo, 1);
    run_op(OP_LSL, half | 1, 0, "lsl");
    run_op(OP_LSR, half | 1, 0, "lsr");
    run_op(OP_NOT, 15, 0, "not");
    run_op(OP_MUL, 0, 0, "mul_zero");
    run_op(OP_MUL, m, 2, "mul_by2");
    run_op(OP_MUL, half, half, "mul_half");

    // Result held under backpressure, then next op loads on release edge.
    @(negedge clk);
    ra = $urandom & m;
    rb = $urandom & m;
    model(w, OP_AND, ra, rb, slo, ehi, sfl);
    op        = OP_AND;
    a         = ra[15:0];
    b         = rb[15:0];
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp.valid", o_ov, 1);
    check("bp.lo", o_lo, slo);
    repeat (3) begin
      @(negedge clk);
      check("bp.hold_valid", o_ov, 1);
      check("bp.hold_lo", o_lo, slo);
      check("bp.hold_flags", o_fl, sfl);
      check("bp.in_ready", o_ir, 0);
    end
    ra = $urandom & m;
    rb = $urandom & m;
    model(w, OP_OR, ra, rb, elo, ehi, efl);
    op        = OP_OR;
    a         = ra[15:0];
    b         = rb[15:0];
    out_ready = 1'b1;
    in_valid  = 1'b1;
    #1;
    check("bp.release_ready", o_ir, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp.next_valid", o_ov, 1);
    check("bp.next_lo", o_lo, elo);
    check("bp.next_flags", o_fl, efl);

`ifndef ALU_FAST_MUL_EN
    // Reset partway through a multiply discards it.
    @(negedge clk);
    op       = OP_MUL;
    a        = m[15:0];
    b        = m[15:0];
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mul.busy_before", o_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mul.valid", o_ov, 0);
    check("rst_mul.busy", o_busy, 0);
    check("rst_mul.in_ready", o_ir, 1);
    repeat (w + 2) @(negedge clk);
    check("rst_mul.no_result", o_ov, 0);
`endif

    repeat (30) begin
      ra = $urandom & m;
      rb = $urandom & m;
      run_op(3'($urandom_range(0, 7)), ra, rb, "rand");
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sel16     = 1'b0;
    op        = '0;
    a         = '0;
    b         = '0;
    cw        = 8;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset.valid8", ov8, 0);
    check("reset.busy8", busy8, 0);
    check("reset.ready8", ir8, 1);
    check("reset.res8", {hi8, lo8}, 0);
    check("reset.flags8", fl8, 0);
    check("reset.valid16", ov16, 0);
    check("reset.res16", {hi16, lo16}, 0);
    check("reset.flags16", fl16, 0);

    run_suite(8);
    run_suite(16);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
